// File: rtl/freq_div_checker.sv
// freq_div_checker: measures period/high time of a divided clock, checks ratio and duty, tracks lock
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   en            enable; low returns to IDLE and clears lock/counters (err_cnt kept)
//   sig_in        divided clock under test, asynchronous to clk
//   period        last measured period in clk cycles
//   high_time     last measured high time in clk cycles
//   meas_valid    one-cycle pulse when period/high_time update
//   lock          LOCK_CNT consecutive matching measurements seen
//   err           one-cycle pulse on a mismatching measurement
//   timeout       one-cycle pulse on loss of clock
//   err_cnt       saturating count of err pulses
module freq_div_checker #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 6,
    parameter int EXP_HIGH   = 3,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             lock,
    output logic             err,
    output logic             timeout,
    output logic [7:0]       err_cnt
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]    LC    = MW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOL_W = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]   EP    = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   EH    = (CNT_W + 1)'(EXP_HIGH);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] per_cnt, hi_cnt, hi_lat;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic             rise, fall, good;

    // |v - e| <= TOL without signed arithmetic: one extra bit absorbs v + TOL
    function automatic logic in_tol(logic [CNT_W-1:0] v, logic [CNT_W:0] e);
        return ({1'b0, v} + TOL_W >= e) && ({1'b0, v} <= e + TOL_W);
    endfunction

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign good      = in_tol(per_cnt, EP) && in_tol(hi_lat, EH);
    assign match_nxt = (match_cnt == LC) ? LC : match_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            {s1, s2, s3} <= '0;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            hi_lat     <= '0;
            match_cnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            lock       <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            s3         <= s2;
            meas_valid <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                per_cnt   <= '0;
                hi_cnt    <= '0;
                hi_lat    <= '0;
                match_cnt <= '0;
                lock      <= 1'b0;
            end else if (state == IDLE) begin
                // the first rise only starts the counters; it closes no period
                per_cnt <= CNT_W'(rise);
                hi_cnt  <= CNT_W'(rise);
                if (rise) state <= ARMED;
            end else begin
                per_cnt <= rise ? CNT_W'(1) : per_cnt + CNT_W'(per_cnt != '1);
                hi_cnt  <= rise ? CNT_W'(1) : hi_cnt + CNT_W'(s2);
                if (fall) hi_lat <= hi_cnt;
                // a rise landing on the timeout value still closes a (bad) period
                if (rise) begin
                    period     <= per_cnt;
                    high_time  <= hi_lat;
                    meas_valid <= 1'b1;
                    if (good) begin
                        match_cnt <= match_nxt;
                        lock      <= (match_nxt == LC);
                    end else begin
                        err       <= 1'b1;
                        err_cnt   <= err_cnt + 8'(err_cnt != 8'hff);
                        match_cnt <= '0;
                        lock      <= 1'b0;
                    end
                end else if (per_cnt == TO) begin
                    timeout   <= 1'b1;
                    lock      <= 1'b0;
                    match_cnt <= '0;
                    per_cnt   <= '0;
                    hi_cnt    <= '0;
                    hi_lat    <= '0;
                    state     <= IDLE;
                end
            end
        end
    end
endmodule
